// File: rtl/mega_mux_of_destiny.sv
// Final result-selection stage of the vALU datapath: 8-to-1 word mux with a
// combinational output, an invalid-select flag, and registered copies of both.
module mega_mux_of_destiny #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSEL  = 4
) (
    output logic [WIDTH-1:0] O,
    input  logic [NSEL-1:0]  S,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] O_q,
    output logic             sel_invalid,
    output logic             sel_invalid_q
);

    logic [WIDTH-1:0] w_in [8];
    logic [WIDTH-1:0] w_o;
    logic             w_sel_invalid;
    logic [WIDTH-1:0] r_o_q;
    logic             r_sel_invalid_q;

    assign w_in[0] = I0;
    assign w_in[1] = I1;
    assign w_in[2] = I2;
    assign w_in[3] = I3;
    assign w_in[4] = I4;
    assign w_in[5] = I5;
    assign w_in[6] = I6;
    assign w_in[7] = I7;

    // Any select bit above the low three marks the code as out of range.
    assign w_sel_invalid = |S[NSEL-1:3];

    // Ternary keeps an X on the select visible as X on the output.
    assign w_o = w_sel_invalid ? '0 : w_in[S[2:0]];

    assign O           = w_o;
    assign sel_invalid = w_sel_invalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_q           <= '0;
            r_sel_invalid_q <= 1'b0;
        end else begin
            r_o_q           <= w_o;
            r_sel_invalid_q <= w_sel_invalid;
        end
    end

    assign O_q           = r_o_q;
    assign sel_invalid_q = r_sel_invalid_q;

endmodule

// File: tb/tb_mega_mux_of_destiny.sv
// Bench for mega_mux_of_destiny: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_mega_mux_of_destiny;

    logic [31:0] O;
    logic [3:0]  S;
    logic [31:0] in_arr [8];
    logic        clk;
    logic        reset;
    logic [31:0] O_q;
    logic        sel_invalid;
    logic        sel_invalid_q;

    int n_tests;
    int n_fail;

    logic [31:0] m_q;
    logic        m_inv_q;
    logic        m_valid;

    mega_mux_of_destiny #(
        .WIDTH(32),
        .NSEL (4)
    ) dut (
        .O            (O),
        .S            (S),
        .I0           (in_arr[0]),
        .I1           (in_arr[1]),
        .I2           (in_arr[2]),
        .I3           (in_arr[3]),
        .I4           (in_arr[4]),
        .I5           (in_arr[5]),
        .I6           (in_arr[6]),
        .I7           (in_arr[7]),
        .clk          (clk),
        .reset        (reset),
        .O_q          (O_q),
        .sel_invalid  (sel_invalid),
        .sel_invalid_q(sel_invalid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_o(input int unsigned s);
        if (s <= 7) return in_arr[s];
        return 32'd0;
    endfunction

    function automatic logic model_inv(input int unsigned s);
        return s > 7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        m_q     <= reset ? 32'd0 : model_o(int'(S));
        m_inv_q <= reset ? 1'b0 : model_inv(int'(S));
        if (reset) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        chk("cmp_O", O, model_o(int'(S)));
        chk("cmp_sel_invalid", {31'd0, sel_invalid}, {31'd0, model_inv(int'(S))});
        if (m_valid) begin
            chk("cmp_O_q", O_q, m_q);
            chk("cmp_sel_invalid_q", {31'd0, sel_invalid_q}, {31'd0, m_inv_q});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pow;
        n_tests = 0;
        n_fail  = 0;
        m_valid = 1'b0;
        reset   = 1'b1;
        S       = 4'd0;
        for (int k = 0; k < 8; k++) in_arr[k] = 32'd0;
        step();
        step();
        chk("reset_O_q", O_q, 32'd0);
        chk("reset_sel_invalid_q", {31'd0, sel_invalid_q}, 32'd0);
        reset = 1'b0;

        // One-hot inputs, combinational selection without waiting for a clock edge.
        step();
        for (int k = 0; k < 8; k++) in_arr[k] = 32'd1 << k;
        for (int k = 0; k < 8; k++) begin
            S = 4'(k);
            #1;
            exp_pow = 32'd1 << k;
            chk("onehot_O", O, exp_pow);
            chk("onehot_sel_invalid", {31'd0, sel_invalid}, 32'd0);
        end
        S = 4'd8;
        #1;
        chk("inv8_O", O, 32'd0);
        chk("inv8_sel_invalid", {31'd0, sel_invalid}, 32'd1);
        S = 4'd15;
        #1;
        chk("inv15_O", O, 32'd0);
        chk("inv15_sel_invalid", {31'd0, sel_invalid}, 32'd1);

        // Unselected inputs must not disturb O.
        step();
        S = 4'd3;
        in_arr[3] = 32'hDEADBEEF;
        #1;
        chk("sel3_O", O, 32'hDEADBEEF);
        in_arr[2] = 32'hFFFFFFFF;
        in_arr[4] = 32'hFFFFFFFF;
        #1;
        chk("unsel_O", O, 32'hDEADBEEF);
        in_arr[3] = 32'h12345678;
        #1;
        chk("sel3_change_O", O, 32'h12345678);

        // Registered path.
        step();
        S = 4'd5;
        in_arr[5] = 32'hA5A5A5A5;
        step();
        chk("reg_O_q", O_q, 32'hA5A5A5A5);
        chk("reg_sel_invalid_q", {31'd0, sel_invalid_q}, 32'd0);
        S = 4'd9;
        step();
        chk("reg_inv_O_q", O_q, 32'd0);
        chk("reg_inv_sel_invalid_q", {31'd0, sel_invalid_q}, 32'd1);

        // Reset clears the registers while the combinational path stays live.
        reset = 1'b1;
        S = 4'd7;
        in_arr[7] = 32'hFFFFFFFF;
        for (int e = 0; e < 2; e++) begin
            step();
            chk("rst_O_q", O_q, 32'd0);
            chk("rst_sel_invalid_q", {31'd0, sel_invalid_q}, 32'd0);
            chk("rst_O", O, 32'hFFFFFFFF);
        end
        reset = 1'b0;
        step();
        chk("postrst_O_q", O_q, 32'hFFFFFFFF);

        // Randomized traffic; the negedge compare process checks every cycle.
        for (int c = 0; c < 400; c++) begin
            S = 4'($urandom_range(0, 15));
            for (int k = 0; k < 8; k++) in_arr[k] = $urandom;
            reset = ($urandom_range(0, 19) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
